aes_keyexp_iter: RTL and testbench
==================================

# aes_keyexp_iter

Iterative, parametrised AES key-schedule engine covering AES-128, AES-192 and AES-256 (NK = 4/6/8). After one key-load handshake it generates one 32-bit schedule word per cycle and streams the NR+1 round keys as 128-bit words over a valid/ready interface with backpressure. It sits between the key register and the round datapath. It replaces the fixed, fully unrolled per-word key-expansion units with a single shared word slice: 4 `sbox` instances, a running Rcon, and an NK-word history.

## Interface
- `WORD`, default 32: schedule word width. Only 32 is supported.
- `NB`, default 4: words per round key. Only 4 is supported.
- `NK`, default 4: key length in words, one of 4, 6 or 8. Any other value is an elaboration error.
- NR is derived as NK+6. NW is derived as NB*(NR+1), giving 44, 52 or 60.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_valid` in 1: key-load request.
- `o_ready` out 1: engine can accept a key.
- `i_key` in NK*WORD: cipher key. w0 is `i_key[NK*WORD-1 -: WORD]` (FIPS-197 byte order).
- `o_rk_valid` out 1: `o_rk` holds a valid round key.
- `i_rk_ready` in 1: consumer accepts `o_rk`.
- `o_rk` out NB*WORD: round key r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in the MSBs.
- `o_rk_idx` out 4: index r of the key in `o_rk`, from 0 to NR.
- `o_busy` out 1: a schedule is in progress.

## Operation
- FSM states: IDLE and GEN.
- IDLE:
  - `o_ready`=1, `o_busy`=0.
  - `i_valid`&`o_ready` at an edge captures `i_key` into the history register, clears the word counter i, sets Rcon=0x01, clears the modulo-NK counter, and moves to GEN.
- GEN:
  - Each advancing edge appends word w[i] to a 4-word assembly buffer, then i increments.
  - For i<NK, w[i] is taken from the captured key.
  - For i≥NK, w[i] = w[i-NK] ^ t, where:
    - i mod NK = 0: t = SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0}. Rcon then updates to xtime(Rcon), so 0x80 becomes 0x1b.
    - NK=8 and i mod 8 = 4: t = SubWord(w[i-1]).
    - Otherwise: t = w[i-1].
  - i mod NK comes from a wrapping counter; no divider is used.
  - The history register is a shift register holding w[i-NK..i-1].
- Round-key completion and stalling:
  - When the appended word is the 4th of a round key, the round key loads directly into `o_rk`, `o_rk_valid` is set, and `o_rk_idx`=i/4.
  - Advance is blocked when the current word would complete a round key, `o_rk_valid`=1 and `i_rk_ready`=0. In that case the history, counters and Rcon all hold.
  - A completed round key may load on the same edge the previous one is accepted, giving full throughput.
- Output handshake:
  - `o_rk_valid` clears on `i_rk_ready` unless a new key loads on that edge.
  - `o_rk` and `o_rk_idx` stay stable while valid and not accepted.
- Completion: after i reaches NW, the FSM returns to IDLE on the edge that accepts round key NR. `o_rk_valid` drops on that edge unless the consumer stalls.
- Reset at any time, including mid-schedule: state=IDLE, `o_rk_valid`=0, `o_rk`=0, `o_rk_idx`=0, `o_busy`=0, `o_ready`=1, Rcon=0x01, counters=0.

## Timing
- Load handshake happens at edge E0.
- With no backpressure, word w[k-1] is appended at edge Ek.
- Round key r is valid after edge E(4r+4): RK0 after E4, RK10 (AES-128) after E44.
- Total time is NW cycles from load to the last round key valid.
- `o_ready` is low from E0 until the return to IDLE. A new key can be loaded on the edge after the final acceptance.
- `i_key` is sampled only at the load edge.

## Configuration
- Macro: `AES_KEYEXP_ABORT_EN`.
- When defined:
  - `o_ready`=1 in both states.
  - `i_valid` in GEN aborts the schedule: `o_rk_valid` clears and the new key loads as in IDLE on the same edge. Any pending round key is discarded.
- When undefined:
  - `o_ready`=0 in GEN.
  - `i_valid` in GEN is ignored with no side effects.

## Test plan
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, `i_rk_ready`=1 → 11 keys. RK0 equals the key, RK1 starts with a0fafe17, RK10 = d014f9a8c9ee2589e13f0cc8b6630ca6. RK10 is valid after E44 and `o_ready` returns.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → 13 keys. w6=fe0c91f7; RK12 = e98ba06f448c773c8ecc720401002202.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → 15 keys. RK2 = 9ba354118e6925afa51a8b5f2067fcde, RK3 starts with a8b09c1a (checks the i mod 8 = 4 SubWord path), RK14 = fe4890d1e6188d0b046df344706c631e.
- AES-128 with `i_rk_ready` held low for 7 cycles while RK3 is valid → `o_rk`/`o_rk_idx`=3 stay stable, no words are lost, and the stream is otherwise identical to the first scenario.
- Assert `rst` asynchronously after RK4 → all outputs take their reset values immediately. A reload then produces a correct RK0 after E4.
- `i_valid` with a second key while in GEN:
  - Macro defined: `o_rk_valid` drops, and the second key's RK0 appears 4 cycles later.
  - Macro undefined: the request is ignored and the first schedule completes unchanged.

Source files
------------

// File: rtl/aes_keyexp_iter.sv
`default_nettype none
// =============================================================================
// Module  : aes_keyexp_iter
// Purpose : Iterative AES-128/192/256 key schedule. Generates one schedule word
//           per cycle and streams round keys over valid/ready.
//           Optional macro AES_KEYEXP_ABORT_EN: a new key request aborts a
//           running schedule.
// Revision: 1.0
// =============================================================================
module aes_keyexp_iter #(
  parameter int WORD = 32,
  parameter int NB   = 4,
  parameter int NK   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NK*WORD-1:0] i_key,
  output logic               o_rk_valid,
  input  logic               i_rk_ready,
  output logic [NB*WORD-1:0] o_rk,
  output logic [3:0]         o_rk_idx,
  output logic               o_busy
);
  localparam int c_NR = NK + 6;
  localparam int c_NW = NB * (c_NR + 1);

  if (!(NK == 4 || NK == 6 || NK == 8) || WORD != 32 || NB != 4) begin : g_bad_cfg
    $error("aes_keyexp_iter: unsupported NK/WORD/NB combination");
  end

  typedef enum logic [0:0] {S_IDLE, S_GEN} state_t;

  function automatic logic [7:0] f_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = f_xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine map
  function automatic logic [7:0] f_sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = f_gmul(sq, sq);
      inv = f_gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WORD-1:0]   r_hist [NK];
  logic [3*WORD-1:0] r_asm;
  logic [5:0]        r_i;
  logic [2:0]        r_mod;
  logic [7:0]        r_rcon;

  logic [WORD-1:0]   w_prev;
  logic [WORD-1:0]   w_sub_in;
  logic [WORD-1:0]   w_sub_out;
  logic [WORD-1:0]   w_t;
  logic [WORD-1:0]   w_new;
  logic              w_load;
  logic              w_adv;
  logic              w_pre_key;
  logic              w_last_word;
  logic              w_done;
  logic              w_stall;

  assign w_prev      = r_hist[NK-1];
  assign w_sub_in    = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign w_pre_key   = (r_i < 6'(NK));
  assign w_last_word = (r_i[1:0] == 2'd3);
  assign w_done      = (r_i == 6'(c_NW));
  assign w_stall     = w_last_word && o_rk_valid && !i_rk_ready;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign w_sub_out[8*b +: 8] = f_sbox(w_sub_in[8*b +: 8]);
  end

  // The history rotates through the captured key for the first NK words, so
  // it naturally ends up holding w[i-NK..i-1] once derivation begins.
  always_comb begin
    w_t = w_prev;
    if (r_mod == 3'd0)
      w_t = w_sub_out ^ {r_rcon, 24'h000000};
    else if (NK == 8 && r_mod == 3'd4)
      w_t = w_sub_out;
    w_new = w_pre_key ? r_hist[0] : (r_hist[0] ^ w_t);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    o_busy      = 1'b0;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_GEN;
        end
      end
      S_GEN: begin
        o_busy = 1'b1;
`ifdef AES_KEYEXP_ABORT_EN
        o_ready = 1'b1;
        w_load  = i_valid;
`endif
        if (!w_load) begin
          if (w_done) begin
            if (o_rk_valid && i_rk_ready) w_state_nxt = S_IDLE;
          end else if (!w_stall) begin
            w_adv = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NK; k++) r_hist[k] <= '0;
      r_asm      <= '0;
      r_i        <= 6'd0;
      r_mod      <= 3'd0;
      r_rcon     <= 8'h01;
      o_rk_valid <= 1'b0;
      o_rk       <= '0;
      o_rk_idx   <= 4'd0;
    end else begin
      if (w_load) begin
        for (int k = 0; k < NK; k++) r_hist[k] <= i_key[(NK-1-k)*WORD +: WORD];
        r_i    <= 6'd0;
        r_mod  <= 3'd0;
        r_rcon <= 8'h01;
      end else if (w_adv) begin
        for (int k = 0; k < NK-1; k++) r_hist[k] <= r_hist[k+1];
        r_hist[NK-1] <= w_new;
        r_asm        <= {r_asm[2*WORD-1:0], w_new};
        r_i          <= r_i + 6'd1;
        r_mod        <= (r_mod == 3'(NK-1)) ? 3'd0 : r_mod + 3'd1;
        if (r_mod == 3'd0 && !w_pre_key) r_rcon <= f_xtime(r_rcon);
      end

      if (w_load) begin
        o_rk_valid <= 1'b0;
      end else if (w_adv && w_last_word) begin
        o_rk_valid <= 1'b1;
        o_rk       <= {r_asm, w_new};
        o_rk_idx   <= r_i[5:2];
      end else if (i_rk_ready) begin
        o_rk_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_keyexp_iter.sv
`default_nettype none
// tb_aes_keyexp_iter : scoreboard and known-answer bench for aes_keyexp_iter,
// one instance each for NK = 4, 6 and 8.
module tb_aes_keyexp_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [255:0] key = '0;
  logic [2:0]   vld = '0;
  logic [2:0]   rkr = '0;
  wire  [2:0]   ordy;
  wire  [2:0]   rkv;
  wire  [2:0]   bsy;
  wire  [127:0] rk [3];
  wire  [3:0]   ix [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_keyexp_iter #(.WORD(32), .NB(4), .NK(4 + 2*g)) u_dut (
      .clk(clk), .rst(rst), .i_valid(vld[g]), .o_ready(ordy[g]),
      .i_key(key[255 -: (4 + 2*g)*32]), .o_rk_valid(rkv[g]), .i_rk_ready(rkr[g]),
      .o_rk(rk[g]), .o_rk_idx(ix[g]), .o_busy(bsy[g])
    );
  end

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] K2   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] MFULL = {128{1'b1}};
  localparam logic [127:0] MW0   = {32'hffffffff, 96'h0};
  localparam logic [127:0] MW2   = {64'h0, 32'hffffffff, 32'h0};

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] rk;
  } exp_t;

  typedef struct {
    int           s;
    int           idx;
    logic [127:0] exp;
    logic [127:0] mask;
  } kat_t;

  exp_t         q[$];
  kat_t         kat [11];
  logic [31:0]  mw [60];
  logic [127:0] got [3][16];
  int           first_seen [16];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  int           c0 = 0;
  int           nrecv = 0;
  int           act = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, a, e);
    end
  endtask

  // ---------------- reference model (textbook FIPS-197 expansion) ----------
  function automatic logic [7:0] m_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = m_xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    logic [7:0] c = 8'h63;
    for (int y = 1; y < 256; y++)
      if (m_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int b = 0; b < 8; b++)
      s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
    return s;
  endfunction

  function automatic logic [31:0] m_subw(input logic [31:0] w);
    return {m_sbox(w[31:24]), m_sbox(w[23:16]), m_sbox(w[15:8]), m_sbox(w[7:0])};
  endfunction

  task automatic expand_push(input int nk, input logic [255:0] k);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    exp_t        e;
    for (int i = 0; i < 4*(nk+7); i++) begin
      if (i < nk) begin
        mw[i] = k[255-32*i -: 32];
      end else begin
        t = mw[i-1];
        if (i % nk == 0) begin
          t  = m_subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = m_xt(rc);
        end else if (nk == 8 && i % nk == 4) begin
          t = m_subw(t);
        end
        mw[i] = mw[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nk + 6; r++) begin
      e.idx = 4'(r);
      e.rk  = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
      q.push_back(e);
    end
  endtask

  // ---------------- monitor / clocking -------------------------------------
  task automatic monitor();
    exp_t e;
    if (rst) return;
    if (rkv[act] && first_seen[ix[act]] < 0) first_seen[ix[act]] = cyc - c0;
    if (rkv[act] && rkr[act]) begin
      nrecv++;
      got[act][ix[act]] = rk[act];
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_extra: got idx %0d key %h, required no further key", ix[act], rk[act]);
      end else begin
        e = q.pop_front();
        chk("sb_idx", 128'(ix[act]), 128'(e.idx));
        chk("sb_rk", rk[act], e.rk);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_sched(input int s, input logic [255:0] k);
    c0    = cyc;
    nrecv = 0;
    for (int j = 0; j < 16; j++) first_seen[j] = -1;
    expand_push(4 + 2*s, k);
  endtask

  task automatic load(input int s, input logic [255:0] k);
    chk("load_ready", 128'(ordy[s]), 128'd1);
    key    = k;
    vld[s] = 1'b1;
    tick();
    vld[s] = 1'b0;
    key    = '0;
    begin_sched(s, k);
    chk("load_busy", 128'(bsy[s]), 128'd1);
  endtask

  task automatic wait_done(input int s, output int t);
    int n = 0;
    while (bsy[s] && n < 300) begin
      tick();
      n++;
    end
    t = cyc - c0;
    chk("done_idle", 128'(bsy[s]), 128'd0);
  endtask

  task automatic wait_key(input int s, input int idx);
    int n = 0;
    while (!(rkv[s] && ix[s] == 4'(idx)) && n < 100) begin
      tick();
      n++;
    end
    chk("reach_key", {124'(rkv[s]), ix[s]}, {124'd1, 4'(idx)});
  endtask

  task automatic run_nom(input int s, input logic [255:0] k);
    int t;
    int nr = 4 + 2*s + 6;
    act    = s;
    rkr[s] = 1'b1;
    load(s, k);
    wait_done(s, t);
    chk("rk0_time", 128'(first_seen[0]), 128'd4);
    chk("last_time", 128'(first_seen[nr]), 128'(4*(nr+1)));
    chk("done_time", 128'(t), 128'(4*(nr+1) + 1));
    chk("nkeys", 128'(nrecv), 128'(nr + 1));
    chk("q_empty", 128'(q.size()), 128'd0);
    chk("ready_back", 128'(ordy[s]), 128'd1);
  endtask

  initial begin
    int t;
    logic [127:0] rk3;

    kat[0]  = '{0,  0, K128[255:128], MFULL};
    kat[1]  = '{0,  1, {32'ha0fafe17, 96'h0}, MW0};
    kat[2]  = '{0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, MFULL};
    kat[3]  = '{1,  0, 128'h8e73b0f7da0e6452c810f32b809079e5, MFULL};
    kat[4]  = '{1,  1, {64'h0, 32'hfe0c91f7, 32'h0}, MW2};
    kat[5]  = '{1, 12, 128'he98ba06f448c773c8ecc720401002202, MFULL};
    kat[6]  = '{2,  0, 128'h603deb1015ca71be2b73aef0857d7781, MFULL};
    kat[7]  = '{2,  1, 128'h1f352c073b6108d72d9810a30914dff4, MFULL};
    kat[8]  = '{2,  2, 128'h9ba354118e6925afa51a8b5f2067fcde, MFULL};
    kat[9]  = '{2,  3, {32'ha8b09c1a, 96'h0}, MW0};
    kat[10] = '{2, 14, 128'hfe4890d1e6188d0b046df344706c631e, MFULL};
    for (int j = 0; j < 16; j++) first_seen[j] = -1;

    // reset state
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      chk("rst_ready", 128'(ordy[s]), 128'd1);
      chk("rst_busy", 128'(bsy[s]), 128'd0);
      chk("rst_valid", 128'(rkv[s]), 128'd0);
      chk("rst_rk", rk[s], 128'd0);
      chk("rst_idx", 128'(ix[s]), 128'd0);
    end
    rst = 1'b0;
    tick();

    // nominal schedules and published known answers
    run_nom(0, K128);
    run_nom(1, K192);
    run_nom(2, K256);
    for (int v = 0; v < 11; v++)
      chk($sformatf("kat%0d", v), got[kat[v].s][kat[v].idx] & kat[v].mask, kat[v].exp & kat[v].mask);

    // backpressure: consumer stalls 7 cycles while RK3 is offered
    act = 0;
    rkr[0] = 1'b1;
    load(0, K128);
    rk3 = {mw[12], mw[13], mw[14], mw[15]};
    wait_key(0, 3);
    rkr[0] = 1'b0;
    repeat (7) begin
      tick();
      chk("stall_valid", 128'(rkv[0]), 128'd1);
      chk("stall_idx", 128'(ix[0]), 128'd3);
      chk("stall_rk", rk[0], rk3);
    end
    rkr[0] = 1'b1;
    wait_done(0, t);
    chk("stall_done_time", 128'(t), 128'd49);
    chk("stall_nkeys", 128'(nrecv), 128'd11);
    chk("stall_q_empty", 128'(q.size()), 128'd0);

    // asynchronous reset mid-schedule, then reload
    load(0, K128);
    wait_key(0, 4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 128'(rkv[0]), 128'd0);
    chk("arst_rk", rk[0], 128'd0);
    chk("arst_idx", 128'(ix[0]), 128'd0);
    chk("arst_busy", 128'(bsy[0]), 128'd0);
    chk("arst_ready", 128'(ordy[0]), 128'd1);
    q.delete();
    tick();
    rst = 1'b0;
    load(0, K2);
    wait_done(0, t);
    chk("reload_rk0_time", 128'(first_seen[0]), 128'd4);
    chk("reload_rk0", got[0][0], K2[255:128]);
    chk("reload_nkeys", 128'(nrecv), 128'd11);
    chk("reload_q_empty", 128'(q.size()), 128'd0);

    // second key request while a schedule is running
    load(0, K128);
    wait_key(0, 1);
`ifdef AES_KEYEXP_ABORT_EN
    chk("gen_ready", 128'(ordy[0]), 128'd1);
`else
    chk("gen_ready", 128'(ordy[0]), 128'd0);
`endif
    key    = K2;
    vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    key    = '0;
`ifdef AES_KEYEXP_ABORT_EN
    chk("abort_valid", 128'(rkv[0]), 128'd0);
    q.delete();
    begin_sched(0, K2);
    wait_done(0, t);
    chk("abort_rk0_time", 128'(first_seen[0]), 128'd4);
    chk("abort_rk0", got[0][0], K2[255:128]);
    chk("abort_nkeys", 128'(nrecv), 128'd11);
`else
    chk("ignore_busy", 128'(bsy[0]), 128'd1);
    wait_done(0, t);
    chk("ignore_done_time", 128'(t), 128'd45);
    chk("ignore_nkeys", 128'(nrecv), 128'd11);
    chk("ignore_rk10", got[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif
    chk("final_q_empty", 128'(q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
